dmem_store_buffer: RTL and testbench
====================================

Name: dmem_store_buffer

Overview:
- Decoupling stage between the single-cycle core's data port (MemWrite/DataAdr/WriteData/ReadData) and a multi-cycle data memory that uses a req/ack handshake.
- Stores are posted into a FIFO and drained in the background.
- Loads are forwarded from the FIFO on an address match, otherwise fetched from memory.
- The core freezes (holds PC, no writeback) while cpu_stall=1.

Parameters:
DEPTH, 4, number of store entries; power of two, >=2
CW, $clog2(DEPTH)+1, width of the count output (derived)

Ports:
clk  input  1  clock; everything updates on posedge
reset  input  1  asynchronous, active-low reset
cpu_we  input  1  store request from the core
cpu_re  input  1  load request from the core
cpu_addr  input  32  byte address; bits [1:0] ignored (word access only)
cpu_wdata  input  32  store data
cpu_rdata  output  32  load data; valid when cpu_re=1 and cpu_stall=0
cpu_stall  output  1  core must hold its current instruction
mem_req  output  1  memory transaction request (registered)
mem_we  output  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  output  32  word address, {addr[31:2],2'b00}
mem_wdata  output  32  write data
mem_ack  input  1  memory completion; sampled only while mem_req=1
mem_rdata  input  32  read data; valid in the cycle mem_ack=1 on a read
count  output  CW  number of occupied FIFO entries
empty  output  1  count==0 and FSM in IDLE (usable as a store fence)

Behaviour:
- Reset (reset=0, async): FIFO emptied, pending stores discarded. FSM=IDLE. mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, read-capture register=0, count=0. Reset mid-transaction drops mem_req immediately.
- FIFO entry: {addr[31:2], data}. Head/tail pointers wrap modulo DEPTH.
- Store accept: cpu_we=1 and count<DEPTH → enqueue at posedge, cpu_stall=0.
- Store when full: count==DEPTH → cpu_stall=1. A dequeue in the same cycle does NOT unstall; the store is accepted the following cycle (no comb path mem_ack→cpu_stall).
- cpu_we and cpu_re both high: illegal. The store is serviced, cpu_re is ignored, and a simulation assertion fires.
- Load forwarding: combinational search over valid entries; the youngest entry with a matching addr[31:2] wins. On hit: cpu_rdata=entry data, cpu_stall=0, zero extra latency. An entry being dequeued at the same edge still forwards.
- Load miss: cpu_stall=1 until the RDONE cycle.
- FSM states: IDLE, WRITE, READ, RDONE.
- IDLE transitions:
  - load miss pending → READ: mem_req=1, mem_we=0, mem_addr=cpu_addr word. Loads take priority over draining.
  - else FIFO non-empty → WRITE: mem_req=1, mem_we=1, addr/data = head entry.
  - else stay in IDLE.
- WRITE: hold mem_req/addr/data stable until mem_ack. On the ack edge: dequeue head, go to IDLE, mem_req=0. A load miss arriving during WRITE waits for this ack.
- READ: hold until mem_ack. On the ack edge: capture mem_rdata, go to RDONE, mem_req=0.
- RDONE (one cycle): cpu_rdata=captured value, cpu_stall=0. A store presented during RDONE is impossible (the core is in the load instruction). Next state is IDLE.
- Minimum latencies:
  - Load miss: 3 cycles (stall in cycle of request and READ cycle, data in RDONE).
  - Drain: enqueue edge, then 1 IDLE cycle, then WRITE; at least 1 idle cycle between consecutive drains.
- count changes:
  - +1 on enqueue, −1 on a write ack.
  - Both on the same edge: unchanged.
  - Never exceeds DEPTH and never underflows.
- cpu_rdata when no valid load: drive 0.

Test Plan:
- Drain, zero-wait: reset, store 0x64←7 at cycle 0, mem_ack=1 whenever mem_req=1.
  - Expected: count=1 after edge 0; mem_req=1, mem_we=1, mem_addr=0x64, mem_wdata=7 in cycle 2; count=0 and mem_req=0 in cycle 3; empty=1.
- Fill and stall: mem_ack tied 0, stores to 0x00,0x04,0x08,0x0C.
  - Expected: count=4; a 5th store to 0x10 gives cpu_stall=1.
  - Then pulse mem_ack once: stall stays 1 that cycle, store accepted next cycle, count=4, first write completed to 0x00.
- Forwarding: mem_ack=0; store 0x64←7, then 0x64←9, then load 0x64.
  - Expected: cpu_rdata=9, cpu_stall=0 in the same cycle; no mem read issued.
- Load miss: FIFO empty, load 0x80, mem_rdata=0x1234 with ack in the 3rd READ cycle.
  - Expected: cpu_stall=1 for 4 cycles, then RDONE with cpu_rdata=0x1234 and stall=0; mem_we=0 and mem_addr=0x80 throughout READ.
- Load behind in-flight write: WRITE to 0x00 pending, then load miss 0x40.
  - Expected: read is not issued until the write ack; the next mem_req has mem_we=0, addr 0x40; the remaining FIFO entries drain only after RDONE.
- Reset mid-drain: 3 stores queued, WRITE active, drive reset=0 for half a cycle.
  - Expected: mem_req drops asynchronously; count=0, empty=1, FSM=IDLE; no further writes after release.

Source files
------------

// File: rtl/dmem_store_buffer_if.sv
// rtl/dmem_store_buffer_if.sv - core data port and multi-cycle memory port bundle for the store buffer
interface dmem_store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
);
    logic          cpu_we;
    logic          cpu_re;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic [CW-1:0] count;
    logic          empty;

    // master is the environment (core plus memory), slave is the store buffer
    modport master (
        output cpu_we, cpu_re, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
        input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata, count, empty
    );

    modport slave (
        input  cpu_we, cpu_re, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
        output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata, count, empty
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - posted-store FIFO with load forwarding between a single-cycle core and a req/ack data memory
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    dmem_store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RDONE} state_t;

    state_t        state, state_d;
    logic [29:0]   fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] head, tail, idx;
    logic [CW-1:0] count;
    logic [31:0]   rcap;

    logic          req_q, we_q, req_d, we_d;
    logic [31:0]   addr_q, wdata_q, addr_d, wdata_d;

    logic          full, load, enq, deq, cap;
    logic          hit, miss, store_stall;
    logic [31:0]   fwd_data;

    assign full        = (count == CW'(DEPTH));
    assign load        = bus.cpu_re & ~bus.cpu_we;
    assign enq         = bus.cpu_we & ~full;
    assign store_stall = bus.cpu_we & full;

    // Walk from oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((CW'(k) < count) && (fifo_addr[idx] == bus.cpu_addr[31:2])) begin
                hit      = 1'b1;
                fwd_data = fifo_data[idx];
            end
        end
    end

    // RDONE is the cycle the missed load completes, so it is never a new miss.
    assign miss = load & ~hit & (state != RDONE);

    always_comb begin
        state_d = state;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        deq     = 1'b0;
        cap     = 1'b0;
        unique case (state)
            IDLE: begin
                if (miss) begin
                    state_d = READ;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = {bus.cpu_addr[31:2], 2'b00};
                end else if (count != '0) begin
                    state_d = WRITE;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = {fifo_addr[head], 2'b00};
                    wdata_d = fifo_data[head];
                end
            end
            WRITE: begin
                if (req_q && bus.mem_ack) begin
                    deq     = 1'b1;
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            READ: begin
                if (req_q && bus.mem_ack) begin
                    cap     = 1'b1;
                    state_d = RDONE;
                    req_d   = 1'b0;
                end
            end
            RDONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rcap    <= '0;
        end else begin
            state   <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (enq) tail <= tail + PW'(1);
            if (deq) head <= head + PW'(1);
            if (enq && !deq)      count <= count + CW'(1);
            else if (deq && !enq) count <= count - CW'(1);
            if (cap) rcap <= bus.mem_rdata;
        end
    end

    // Entry storage needs no reset: validity is carried entirely by head/count.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr[tail] <= bus.cpu_addr[31:2];
            fifo_data[tail] <= bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(bus.cpu_we && bus.cpu_re))
            else $error("dmem_store_buffer: cpu_we and cpu_re asserted together, load ignored");
        end
    end

    assign bus.cpu_rdata = !load              ? 32'd0 :
                           hit                ? fwd_data :
                           (state == RDONE)   ? rcap : 32'd0;
    assign bus.cpu_stall = store_stall | miss;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.count     = count;
    assign bus.empty     = (count == '0) && (state == IDLE);
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb/tb_dmem_store_buffer.sv - directed and randomized checks of dmem_store_buffer against a memory and program-order model
module tb_dmem_store_buffer;
    localparam int DEPTH      = 4;
    localparam int ACK_MANUAL = 0;
    localparam int ACK_ALWAYS = 1;
    localparam int ACK_RAND   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_store_buffer_if #(.DEPTH(DEPTH)) bus ();
    dmem_store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [31:0] mem_q  [logic [29:0]];
    logic [31:0] arch_q [logic [29:0]];
    logic [61:0] wq [$];
    int          exp_cnt  = 0;
    int          ack_mode = ACK_MANUAL;
    logic        man_ack  = 1'b0;

    function automatic logic [31:0] init_val(input logic [29:0] w);
        return {w[15:0], 16'h5a3c} ^ 32'h1357_0000;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [29:0] w);
        return mem_q.exists(w) ? mem_q[w] : init_val(w);
    endfunction

    function automatic logic [31:0] arch_rd(input logic [29:0] w);
        return arch_q.exists(w) ? arch_q[w] : init_val(w);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_mem();
        case (ack_mode)
            ACK_ALWAYS: bus.mem_ack = bus.mem_req;
            ACK_RAND:   bus.mem_ack = ($urandom_range(0, 1) == 1);
            default:    bus.mem_ack = man_ack;
        endcase
        bus.mem_rdata = mem_rd(bus.mem_addr[31:2]);
    endtask

    // Observes one cycle: stores retire in program order, memory holds what was acked.
    task automatic monitor();
        logic [61:0] e;
        logic        fwd;
        if (reset !== 1'b1) return;
        chk("count", 32'(bus.count), 32'(exp_cnt));
        if (bus.cpu_we)
            chk("store_stall", 32'(bus.cpu_stall), 32'(exp_cnt == DEPTH));
        if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
            e = (wq.size() != 0) ? wq.pop_front() : '1;
            chk("write_addr", bus.mem_addr, {e[61:32], 2'b00});
            chk("write_data", bus.mem_wdata, e[31:0]);
            mem_q[bus.mem_addr[31:2]] = bus.mem_wdata;
            exp_cnt--;
        end
        if (bus.cpu_re && !bus.cpu_we) begin
            fwd = 1'b0;
            foreach (wq[i]) if (wq[i][61:32] == bus.cpu_addr[31:2]) fwd = 1'b1;
            if (fwd) chk("fwd_no_stall", 32'(bus.cpu_stall), 32'd0);
            if (!bus.cpu_stall) chk("load_data", bus.cpu_rdata, arch_rd(bus.cpu_addr[31:2]));
        end
        if (bus.cpu_we && !bus.cpu_stall) begin
            wq.push_back({bus.cpu_addr[31:2], bus.cpu_wdata});
            arch_q[bus.cpu_addr[31:2]] = bus.cpu_wdata;
            exp_cnt++;
        end
    endtask

    task automatic step(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        drive_mem();
        bus.cpu_we    = we;
        bus.cpu_re    = re;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        @(negedge clk);
        monitor();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic drain(input string tag);
        ack_mode = ACK_ALWAYS;
        for (int i = 0; i < 60 && bus.empty !== 1'b1; i++) idle();
        chk({tag, "_empty"}, 32'(bus.empty), 32'd1);
        chk({tag, "_pending"}, 32'(wq.size()), 32'd0);
    endtask

    initial begin
        int          stalls, max_stall, reqs, r;
        logic        we, re;
        logic [31:0] a, d;

        reset         = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_re    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        mem_q[30'h20]  = 32'h1234;
        arch_q[30'h20] = 32'h1234;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_rdata", bus.cpu_rdata, 32'd0);

        // zero-wait drain
        ack_mode = ACK_ALWAYS;
        step(1'b1, 1'b0, 32'h64, 32'd7);
        chk("drain_c0_stall", 32'(bus.cpu_stall), 32'd0);
        idle();
        chk("drain_c1_req", 32'(bus.mem_req), 32'd0);
        idle();
        chk("drain_c2_req", 32'(bus.mem_req), 32'd1);
        chk("drain_c2_we", 32'(bus.mem_we), 32'd1);
        chk("drain_c2_addr", bus.mem_addr, 32'h64);
        chk("drain_c2_wdata", bus.mem_wdata, 32'd7);
        idle();
        chk("drain_c3_req", 32'(bus.mem_req), 32'd0);
        chk("drain_c3_empty", 32'(bus.empty), 32'd1);

        // fill and stall
        ack_mode = ACK_MANUAL;
        man_ack  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'(i * 4), 32'h100 + 32'(i));
            chk("fill_stall", 32'(bus.cpu_stall), 32'd0);
        end
        step(1'b1, 1'b0, 32'h10, 32'h104);
        chk("full_stall", 32'(bus.cpu_stall), 32'd1);
        chk("full_write_addr", bus.mem_addr, 32'h0);
        chk("full_write_we", 32'(bus.mem_we & bus.mem_req), 32'd1);
        man_ack = 1'b1;
        step(1'b1, 1'b0, 32'h10, 32'h104);
        chk("full_ack_stall", 32'(bus.cpu_stall), 32'd1);
        man_ack = 1'b0;
        step(1'b1, 1'b0, 32'h10, 32'h104);
        chk("full_accept_stall", 32'(bus.cpu_stall), 32'd0);
        idle();
        chk("full_refill_count", 32'(bus.count), 32'd4);
        drain("fill");

        // forwarding, youngest wins, low address bits ignored
        ack_mode = ACK_MANUAL;
        man_ack  = 1'b0;
        step(1'b1, 1'b0, 32'h64, 32'd7);
        step(1'b1, 1'b0, 32'h64, 32'd9);
        step(1'b0, 1'b1, 32'h64, 32'd0);
        chk("fwd_data", bus.cpu_rdata, 32'd9);
        chk("fwd_stall", 32'(bus.cpu_stall), 32'd0);
        chk("fwd_no_read", 32'(bus.mem_req & ~bus.mem_we), 32'd0);
        step(1'b0, 1'b1, 32'h67, 32'd0);
        chk("fwd_lowbits", bus.cpu_rdata, 32'd9);
        chk("fwd_no_read2", 32'(bus.mem_req & ~bus.mem_we), 32'd0);
        drain("fwd");

        // load miss, ack in the third READ cycle
        ack_mode = ACK_MANUAL;
        for (int i = 0; i < 4; i++) begin
            man_ack = (i == 3);
            step(1'b0, 1'b1, 32'h80, 32'd0);
            chk("miss_stall", 32'(bus.cpu_stall), 32'd1);
            if (i > 0) begin
                chk("miss_req", 32'(bus.mem_req), 32'd1);
                chk("miss_we", 32'(bus.mem_we), 32'd0);
                chk("miss_addr", bus.mem_addr, 32'h80);
            end
        end
        man_ack = 1'b0;
        step(1'b0, 1'b1, 32'h80, 32'd0);
        chk("miss_rdone_stall", 32'(bus.cpu_stall), 32'd0);
        chk("miss_rdone_data", bus.cpu_rdata, 32'h1234);
        idle();
        chk("miss_after_req", 32'(bus.mem_req), 32'd0);
        chk("miss_after_rdata", bus.cpu_rdata, 32'd0);

        // load miss behind an in-flight write
        step(1'b1, 1'b0, 32'h0, 32'hA0);
        step(1'b1, 1'b0, 32'h4, 32'hA4);
        for (int i = 0; i < 3; i++) begin
            man_ack = (i == 2);
            step(1'b0, 1'b1, 32'h40, 32'd0);
            chk("lw_stall", 32'(bus.cpu_stall), 32'd1);
            chk("lw_write_we", 32'(bus.mem_we & bus.mem_req), 32'd1);
            chk("lw_write_addr", bus.mem_addr, 32'h0);
        end
        man_ack = 1'b0;
        step(1'b0, 1'b1, 32'h40, 32'd0);
        chk("lw_idle_req", 32'(bus.mem_req), 32'd0);
        chk("lw_idle_stall", 32'(bus.cpu_stall), 32'd1);
        man_ack = 1'b1;
        step(1'b0, 1'b1, 32'h40, 32'd0);
        chk("lw_read_req", 32'(bus.mem_req), 32'd1);
        chk("lw_read_we", 32'(bus.mem_we), 32'd0);
        chk("lw_read_addr", bus.mem_addr, 32'h40);
        man_ack = 1'b0;
        step(1'b0, 1'b1, 32'h40, 32'd0);
        chk("lw_rdone_stall", 32'(bus.cpu_stall), 32'd0);
        chk("lw_rdone_data", bus.cpu_rdata, init_val(30'h10));
        chk("lw_rdone_req", 32'(bus.mem_req), 32'd0);
        idle();
        chk("lw_post_req", 32'(bus.mem_req), 32'd0);
        idle();
        chk("lw_drain_addr", bus.mem_addr, 32'h4);
        chk("lw_drain_we", 32'(bus.mem_we & bus.mem_req), 32'd1);
        drain("lw");

        // reset while a write is outstanding
        ack_mode = ACK_MANUAL;
        man_ack  = 1'b0;
        step(1'b1, 1'b0, 32'h10, 32'hB0);
        step(1'b1, 1'b0, 32'h14, 32'hB4);
        step(1'b1, 1'b0, 32'h18, 32'hB8);
        idle();
        chk("mid_req", 32'(bus.mem_req), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_empty", 32'(bus.empty), 32'd1);
        wq.delete();
        exp_cnt = 0;
        arch_q  = mem_q;
        @(posedge clk);
        #1 reset = 1'b1;
        ack_mode = ACK_ALWAYS;
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            idle();
            if (bus.mem_req) reqs++;
        end
        chk("mid_post_reqs", 32'(reqs), 32'd0);
        chk("mid_post_empty", 32'(bus.empty), 32'd1);

        // randomized traffic; a stalled instruction is held until it completes
        ack_mode  = ACK_RAND;
        stalls    = 0;
        max_stall = 0;
        we = 1'b0; re = 1'b0; a = '0; d = '0;
        for (int c = 0; c < 2000; c++) begin
            if (!bus.cpu_stall) begin
                r  = int'($urandom_range(0, 9));
                we = (r < 4);
                re = (r >= 4) && (r < 7);
                a  = 32'h100 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
                d  = $urandom;
            end
            step(we, re, a, d);
            stalls    = bus.cpu_stall ? stalls + 1 : 0;
            max_stall = (stalls > max_stall) ? stalls : max_stall;
        end
        chk("rand_stall_bounded", 32'(max_stall < 60), 32'd1);
        drain("rand");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
